load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 9 +
 rtl/lsu_byte_lane.sv | 29 ++
 rtl/load_store_unit.sv | 94 +++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// riscv_structures: shared LSU state encoding and RV32I load/store width codes.
package riscv_structures;
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: extracts/extends load lanes and merges sub-word store data into a word.
module lsu_byte_lane
  import riscv_structures::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    load_val = funct3 == F3_B  ? {{24{b[7]}}, b} :
               funct3 == F3_BU ? {24'b0, b} :
               funct3 == F3_H  ? {{16{h[15]}}, h} :
               funct3 == F3_HU ? {16'b0, h} : word;
    store_word = word;
    if (funct3 == F3_B)
      store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
    else if (funct3 == F3_H)
      store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
    else
      store_word = wdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding LSU with sub-word extraction and read-modify-write stores.
// Define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module load_store_unit
  import riscv_structures::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);
  lsu_state_t        state, state_nx;
  logic              is_store_q, bad_f3, misalign, req_err, is_sw;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, merge_q, load_val, store_word;
  always_comb begin
    bad_f3 = req_is_store ? (req_funct3 > F3_W)
                          : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    req_err = bad_f3 || misalign;
  end
  lsu_byte_lane u_lane (
    .word      (state == MERGE ? merge_q : mem_read_data),
    .addr_lo   (addr_q[1:0]),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .load_val  (load_val),
    .store_word(store_word)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (req_err ? RESP : ACCESS) : IDLE;
      ACCESS:  state_nx = (is_store_q && f3_q != F3_W) ? MERGE : RESP;
      MERGE:   state_nx = RESP;
      default: state_nx = resp_ready ? IDLE : RESP;
    endcase
  end
  // Write strobe is decoded from state so an async reset kills it at once.
  always_comb begin
    is_sw            = state == ACCESS && is_store_q && f3_q == F3_W;
    req_ready        = state == IDLE;
    resp_valid       = state == RESP;
    mem_address      = (state == ACCESS || state == MERGE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_write_enable = is_sw || state == MERGE;
    mem_write_data   = mem_write_enable ? store_word : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      f3_q       <= 3'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        is_store_q <= req_is_store;
        f3_q       <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        resp_rdata <= '0;
        resp_error <= req_err;
      end
      if (state == ACCESS) begin
        merge_q <= mem_read_data;
        if (!is_store_q) resp_rdata <= load_val;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of loads, stores, errors, backpressure and reset.
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_is_store = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, mem_write_enable;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic [31:0] mem [64];
  int          checks = 0, errors = 0, wr_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write_enable) begin
    mem[mem_address[7:2]] <= mem_write_data;
    wr_cnt <= wr_cnt + 1;
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_resp();
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output logic err, output int writes);
    int w0;
    w0 = wr_cnt;
    issue(st, f3, a, wd, lat);
    rd = resp_rdata; err = resp_error; writes = wr_cnt - w0;
    finish_resp();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_error, mem_write_enable} !== 4'b1000 ||
        resp_rdata !== 0 || mem_address !== 0 || mem_write_data !== 0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b err=%b we=%b rd=%h ad=%h wd=%h required 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_error, mem_write_enable, resp_rdata, mem_address, mem_write_data);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
    logic [31:0] ad [4] = '{32'h03, 32'h03, 32'h00, 32'h02};
    logic [31:0] ex [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000BEEF, 32'hFFFFDEAD};
    int lat, w; logic [31:0] rd; logic err;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, f3[i], ad[i], 32'h0, lat, rd, err, w);
      checks++;
      if (rd !== ex[i] || err !== 1'b0 || lat != 2 || w != 0) begin
        errors++;
        $display("FAIL load%0d: rdata=%h err=%b lat=%0d writes=%0d required %h 0 2 0", i, rd, err, lat, w, ex[i]);
      end
    end
  endtask

  task automatic test_sub_stores();
    int lat, w; logic [31:0] rd; logic err;
    xact(1'b1, 3'b000, 32'h79, 32'h00000055, lat, rd, err, w);
    checks++;
    if (mem[30] !== 32'hFFFF55FF || w != 1 || lat != 3 || err !== 1'b0 || rd !== 0) begin
      errors++;
      $display("FAIL sb: word=%h writes=%0d lat=%0d err=%b rd=%h required FFFF55FF 1 3 0 0", mem[30], w, lat, err, rd);
    end
  endtask

  task automatic test_word_store();
    int lat, w; logic [31:0] rd; logic err;
    xact(1'b1, 3'b010, 32'h78, 32'h12345678, lat, rd, err, w);
    checks++;
    if (mem[30] !== 32'h12345678 || w != 1 || lat != 2) begin
      errors++;
      $display("FAIL sw: word=%h writes=%0d lat=%0d required 12345678 1 2", mem[30], w, lat);
    end
    xact(1'b0, 3'b010, 32'h78, 32'h0, lat, rd, err, w);
    checks++;
    if (rd !== 32'h12345678 || lat != 2 || w != 0) begin
      errors++;
      $display("FAIL lw_after_sw: rdata=%h lat=%0d writes=%0d required 12345678 2 0", rd, lat, w);
    end
    xact(1'b1, 3'b001, 32'h7A, 32'h0000CAFE, lat, rd, err, w);
    checks++;
    if (mem[30] !== 32'hCAFE5678 || w != 1 || lat != 3) begin
      errors++;
      $display("FAIL sh: word=%h writes=%0d lat=%0d required CAFE5678 1 3", mem[30], w, lat);
    end
  endtask

  task automatic test_misalign();
    int lat, w; logic [31:0] rd; logic err;
    xact(1'b0, 3'b010, 32'h82, 32'h0, lat, rd, err, w);
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (rd !== 0 || err !== 1'b1 || lat != 1 || w != 0) begin
      errors++;
      $display("FAIL lw_misalign: rdata=%h err=%b lat=%0d writes=%0d required 0 1 1 0", rd, err, lat, w);
    end
`else
    if (rd !== 32'hAB0BAB0B || err !== 1'b0 || lat != 2 || w != 0) begin
      errors++;
      $display("FAIL lw_misalign: rdata=%h err=%b lat=%0d writes=%0d required AB0BAB0B 0 2 0", rd, err, lat, w);
    end
`endif
  endtask

  task automatic test_hold_error();
    int lat, w0;
    w0 = wr_cnt;
    issue(1'b0, 3'b111, 32'h80, 32'h0, lat);
    checks++;
    if (lat != 1 || resp_error !== 1'b1 || resp_rdata !== 0) begin
      errors++;
      $display("FAIL bad_f3: lat=%0d err=%b rdata=%h required 1 1 0", lat, resp_error, resp_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: vld=%b err=%b rdata=%h rdy=%b required 1 1 0 0", i, resp_valid, resp_error, resp_rdata, req_ready);
      end
    end
    finish_resp();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || wr_cnt != w0) begin
      errors++;
      $display("FAIL after_hold: rdy=%b vld=%b writes=%0d required 1 0 0", req_ready, resp_valid, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_in_merge();
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h01; req_wdata = 32'h11;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL merge_we: we=%b required 1", mem_write_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write_enable !== 1'b0 || mem_address !== 0 || mem_write_data !== 0) begin
      errors++;
      $display("FAIL rst_we: we=%b ad=%h wd=%h required 0 0 0", mem_write_enable, mem_address, mem_write_data);
    end
    @(posedge clk); #1;
    checks++;
    if (mem[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_mem: word=%h required DEADBEEF", mem[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_release: vld=%b rdy=%b word=%h required 0 1 DEADBEEF", resp_valid, req_ready, mem[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'hDEADBEEF; mem[30] = 32'hFFFFFFFF; mem[32] = 32'hAB0BAB0B;
    test_reset();
    test_loads();
    test_sub_stores();
    test_word_store();
    test_misalign();
    test_hold_error();
    test_reset_in_merge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
